// File: rtl/midi_rx_if.sv
// MIDI receiver bus: serial line in, note/velocity/gate/strobe outputs out.
// The receiver uses the master modport; the consumer uses the slave modport.
interface midi_rx_if;
    logic       rx_i;
    logic [7:0] note_o;
    logic [6:0] velocity_o;
    logic       gate_o;
    logic       nrstPhase_o;
    logic       frameErr_o;

    modport master (
        input  rx_i,
        output note_o,
        output velocity_o,
        output gate_o,
        output nrstPhase_o,
        output frameErr_o
    );

    modport slave (
        output rx_i,
        input  note_o,
        input  velocity_o,
        input  gate_o,
        input  nrstPhase_o,
        input  frameErr_o
    );
endinterface

// File: rtl/midi_rx.sv
// MIDI UART receiver with monophonic Note On/Off parser and running status.
// Define MIDI_OMNI_EN to accept Note On/Off on all 16 channels.
module midi_rx #(
    parameter int CLK_HZ  = 10000000,
    parameter int BAUD    = 31250,
    parameter int CHANNEL = 0
) (
    input  logic      clk_i,
    input  logic      nrst_i,
    midi_rx_if.master bus
);

    localparam int BIT_CNT = CLK_HZ / BAUD;
    localparam int CNT_W   = $clog2(BIT_CNT);
    localparam logic [CNT_W-1:0] FULL_LD = CNT_W'(BIT_CNT - 1);
    localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(BIT_CNT / 2 - 1);
    localparam logic [3:0]       CHAN    = 4'(CHANNEL);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } rx_state_t;

    typedef enum logic [1:0] {
        RS_NONE,
        RS_IGNORE,
        RS_ON,
        RS_OFF
    } run_status_t;

    // Line synchroniser and edge detector
    logic sync1;
    logic sync2;
    logic line_prev;
    logic fall;

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            line_prev <= 1'b1;
        end else begin
            sync1     <= bus.rx_i;
            sync2     <= sync1;
            line_prev <= sync2;
        end
    end

    assign fall = line_prev & ~sync2;

    // Receiver FSM
    rx_state_t        state;
    rx_state_t        state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_n;
    logic [7:0]       shreg;
    logic [7:0]       shreg_n;
    logic             stop_ok;
    logic             stop_ok_n;
    logic             frame_err;
    logic             frame_err_n;
    logic             byte_stb;
    logic             tick;

    assign tick = (cnt == '0);

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            stop_ok   <= 1'b0;
            frame_err <= 1'b0;
            byte_stb  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            shreg     <= shreg_n;
            stop_ok   <= stop_ok_n;
            frame_err <= frame_err_n;
            byte_stb  <= stop_ok;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        bit_idx_n   = bit_idx;
        shreg_n     = shreg;
        stop_ok_n   = 1'b0;
        frame_err_n = 1'b0;
        case (state)
            S_IDLE: begin
                if (fall) begin
                    state_n = S_START;
                    cnt_n   = HALF_LD;
                end
            end
            S_START: begin
                if (!tick) begin
                    cnt_n = cnt - 1'b1;
                end else if (!sync2) begin
                    state_n   = S_DATA;
                    cnt_n     = FULL_LD;
                    bit_idx_n = '0;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_DATA: begin
                if (!tick) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    shreg_n = {sync2, shreg[7:1]};
                    cnt_n   = FULL_LD;
                    if (bit_idx == 3'd7) begin
                        state_n = S_STOP;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (!tick) begin
                    cnt_n = cnt - 1'b1;
                end else if (sync2) begin
                    stop_ok_n = 1'b1;
                    state_n   = S_IDLE;
                end else begin
                    frame_err_n = 1'b1;
                    state_n     = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (sync2) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Byte classification; shreg stays stable for many cycles after the stop bit
    logic is_realtime;
    logic is_system;
    logic chan_ok;

    assign is_realtime = (shreg[7:3] == 5'b11111);
    assign is_system   = (shreg[7:4] == 4'hF);
`ifdef MIDI_OMNI_EN
    assign chan_ok = 1'b1;
`else
    assign chan_ok = (shreg[3:0] == CHAN);
`endif

    // Note parser
    run_status_t run_status;
    logic        data_idx;
    logic [6:0]  key;
    logic [6:0]  note;
    logic [6:0]  velocity;
    logic        gate;
    logic        phase_rst;

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            run_status <= RS_NONE;
            data_idx   <= 1'b0;
            key        <= '0;
            note       <= '0;
            velocity   <= '0;
            gate       <= 1'b0;
            phase_rst  <= 1'b0;
        end else begin
            phase_rst <= 1'b0;
            if (byte_stb && !is_realtime) begin
                if (shreg[7]) begin
                    data_idx <= 1'b0;
                    if (is_system) begin
                        run_status <= RS_NONE;
                    end else if (shreg[7:4] == 4'h9 && chan_ok) begin
                        run_status <= RS_ON;
                    end else if (shreg[7:4] == 4'h8 && chan_ok) begin
                        run_status <= RS_OFF;
                    end else begin
                        run_status <= RS_IGNORE;
                    end
                end else if (run_status == RS_ON || run_status == RS_OFF) begin
                    if (!data_idx) begin
                        key      <= shreg[6:0];
                        data_idx <= 1'b1;
                    end else begin
                        data_idx <= 1'b0;
                        // Running status is kept so further data pairs repeat the message
                        if (run_status == RS_ON && shreg[6:0] != '0) begin
                            note      <= key;
                            velocity  <= shreg[6:0];
                            gate      <= 1'b1;
                            phase_rst <= 1'b1;
                        end else if (gate && key == note) begin
                            gate <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign bus.note_o      = {1'b0, note};
    assign bus.velocity_o  = velocity;
    assign bus.gate_o      = gate;
    assign bus.nrstPhase_o = phase_rst;
    assign bus.frameErr_o  = frame_err;

endmodule

// File: tb/tb_midi_rx.sv
// Self-checking bench for midi_rx: serial stimulus, expected phase-reset
// strobes queued with their due cycle and matched by a monitor.
module tb_midi_rx;

    localparam int CLK_HZ  = 10000000;
    localparam int BAUD_TB = 62500;
    localparam int BIT     = CLK_HZ / BAUD_TB;
    // sync (2) + edge detect (1) + half bit + 9 bits to stop sample + 2 to outputs
    localparam int LAT     = 3 + BIT / 2 + 9 * BIT + 2;
    localparam int GLITCH  = BIT * 100 / 320;
`ifdef MIDI_OMNI_EN
    localparam bit OMNI = 1'b1;
`else
    localparam bit OMNI = 1'b0;
`endif

    logic clk = 1'b0;
    logic nrst = 1'b0;
    midi_rx_if bus ();

    always #5 clk = ~clk;

    midi_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD_TB),
        .CHANNEL(0)
    ) dut (
        .clk_i (clk),
        .nrst_i(nrst),
        .bus   (bus)
    );

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int ferr_cnt = 0;
    int exp_q[$];
    logic prev_phase = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] n, input logic [6:0] v,
                             input logic g);
        @(negedge clk);
        check_eq({tag, "_note"}, bus.note_o, n);
        check_eq({tag, "_vel"}, bus.velocity_o, v);
        check_eq({tag, "_gate"}, bus.gate_o, g);
    endtask

    // abort_at >= 0 pulses reset halfway through that frame bit and abandons the byte
    task automatic send_byte(input logic [7:0] b, input logic stop, input bit pulse,
                             input int abort_at = -1);
        logic [9:0] frame;
        int start;
        frame = {stop, b, 1'b0};
        @(posedge clk);
        #1;
        start = cyc;
        if (pulse) exp_q.push_back(start + LAT);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                repeat (BIT) @(posedge clk);
                #1;
            end
            bus.rx_i = frame[i];
            if (i == abort_at) begin
                repeat (BIT / 2) @(posedge clk);
                #1;
                nrst = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                bus.rx_i = 1'b1;
                nrst = 1'b1;
                return;
            end
        end
        repeat (BIT) @(posedge clk);
        #1;
        bus.rx_i = 1'b1;
    endtask

    always @(negedge clk) begin
        if (nrst) begin
            if (bus.nrstPhase_o === 1'b1) begin
                if (exp_q.size() == 0) check_eq("phase_unexpected", bus.nrstPhase_o, 0);
                else check_eq("phase_cycle", cyc, exp_q.pop_front());
            end
            if (prev_phase) check_eq("phase_width", bus.nrstPhase_o, 0);
            if (bus.frameErr_o === 1'b1) ferr_cnt++;
        end
        prev_phase = bus.nrstPhase_o;
    end

    initial begin
        bus.rx_i = 1'b1;
        nrst = 1'b0;
        repeat (4) @(posedge clk);
        check_out("reset", 8'h00, 7'h00, 1'b0);
        check_eq("reset_phase", bus.nrstPhase_o, 0);
        check_eq("reset_ferr", bus.frameErr_o, 0);
        #1 nrst = 1'b1;
        repeat (20) @(posedge clk);

        // Basic Note On, latency checked by the monitor
        send_byte(8'h90, 1'b1, 1'b0);
        send_byte(8'h3C, 1'b1, 1'b0);
        send_byte(8'h64, 1'b1, 1'b1);
        check_out("basic", 8'h3C, 7'h64, 1'b1);

        // Running status retrigger
        send_byte(8'h40, 1'b1, 1'b0);
        send_byte(8'h50, 1'b1, 1'b1);
        check_out("running", 8'h40, 7'h50, 1'b1);

        // Note Off with non-matching key
        send_byte(8'h80, 1'b1, 1'b0);
        send_byte(8'h3C, 1'b1, 1'b0);
        send_byte(8'h00, 1'b1, 1'b0);
        check_out("off_nomatch", 8'h40, 7'h50, 1'b1);

        // Matching Note Off under running status
        send_byte(8'h40, 1'b1, 1'b0);
        send_byte(8'h00, 1'b1, 1'b0);
        check_out("off_match", 8'h40, 7'h50, 1'b0);

        // Realtime bytes interleaved, then velocity-0 off
        send_byte(8'h90, 1'b1, 1'b0);
        send_byte(8'hF8, 1'b1, 1'b0);
        send_byte(8'h3C, 1'b1, 1'b0);
        send_byte(8'hFE, 1'b1, 1'b0);
        send_byte(8'h64, 1'b1, 1'b1);
        check_out("realtime", 8'h3C, 7'h64, 1'b1);
        send_byte(8'h3C, 1'b1, 1'b0);
        send_byte(8'h00, 1'b1, 1'b0);
        check_out("vel0_off", 8'h3C, 7'h64, 1'b0);

        // Channel 1 message
        send_byte(8'h91, 1'b1, 1'b0);
        send_byte(8'h3C, 1'b1, 1'b0);
        send_byte(8'h64, 1'b1, OMNI);
        check_out("channel", 8'h3C, 7'h64, OMNI);

        // Short low glitch
        @(posedge clk);
        #1 bus.rx_i = 1'b0;
        repeat (GLITCH) @(posedge clk);
        #1 bus.rx_i = 1'b1;
        repeat (2 * BIT) @(posedge clk);
        check_out("glitch", 8'h3C, 7'h64, OMNI);
        check_eq("glitch_ferr", ferr_cnt, 0);

        // Framing error then a valid message
        send_byte(8'h90, 1'b0, 1'b0);
        repeat (BIT) @(posedge clk);
        check_out("frame_err", 8'h3C, 7'h64, OMNI);
        check_eq("frame_err_count", ferr_cnt, 1);
        send_byte(8'h90, 1'b1, 1'b0);
        send_byte(8'h3C, 1'b1, 1'b0);
        send_byte(8'h64, 1'b1, 1'b1);
        check_out("after_ferr", 8'h3C, 7'h64, 1'b1);

        // System byte between status and data discards the data
        send_byte(8'h90, 1'b1, 1'b0);
        send_byte(8'hF0, 1'b1, 1'b0);
        send_byte(8'h45, 1'b1, 1'b0);
        send_byte(8'h55, 1'b1, 1'b0);
        check_out("sysex_clear", 8'h3C, 7'h64, 1'b1);

        // Reset during data bit 4 (frame bit 5)
        send_byte(8'h90, 1'b1, 1'b0, 5);
        repeat (2 * BIT) @(posedge clk);
        check_out("abort", 8'h00, 7'h00, 1'b0);
        check_eq("abort_phase", bus.nrstPhase_o, 0);
        check_eq("abort_ferr", bus.frameErr_o, 0);
        send_byte(8'h90, 1'b1, 1'b0);
        send_byte(8'h45, 1'b1, 1'b0);
        send_byte(8'h55, 1'b1, 1'b1);
        check_out("after_abort", 8'h45, 7'h55, 1'b1);

        repeat (10) @(posedge clk);
        @(negedge clk);
        check_eq("pending_pulses", exp_q.size(), 0);
        check_eq("total_ferr", ferr_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/midi_rx.md
Name: midi_rx

Overview:
- Serial MIDI receiver and monophonic note parser feeding the oscillator's note_i / nrstPhase_i inputs.
- Deserialises the 31.25 kbaud MIDI UART stream and decodes Note On / Note Off, including running status.
- Holds current note, velocity and gate; pulses a phase-reset strobe on every new Note On.

Parameters:
- CLK_HZ, 10000000, system clock frequency in Hz.
- BAUD, 31250, serial bit rate.
- CHANNEL, 0, MIDI channel 0-15 accepted when omni mode is compiled out.

Ports:
- clk_i  in  1  system clock.
- nrst_i  in  1  asynchronous active-low reset.
- rx_i  in  1  MIDI serial line, idle high, asynchronous to clk_i.
- note_o  out  8  current MIDI key; bit 7 always 0.
- velocity_o  out  7  velocity of the last accepted Note On.
- gate_o  out  1  high while the current note is held.
- nrstPhase_o  out  1  one-cycle pulse on each accepted Note On.
- frameErr_o  out  1  one-cycle pulse when a byte fails its stop-bit check.

Behaviour:
- Interface: reset nrst_i, asynchronous, active-low; clock clk_i. All state resets asynchronously.
- Reset values:
  - note_o = 0, velocity_o = 0, gate_o = 0, nrstPhase_o = 0, frameErr_o = 0.
  - Synchroniser flops = 1. Running status = none.
- Bit timing:
  - BIT_CNT = CLK_HZ/BAUD, truncated; 320 at defaults.
  - Bit counter width = $clog2(BIT_CNT).
- Input: rx_i passes through a 2-FF synchroniser. All edge detection and sampling use the synchronised value.
- RX state machine (IDLE, START, DATA, STOP, WAIT_IDLE):
  - IDLE: a falling edge starts a BIT_CNT/2 wait, then START.
  - START: line still low -> DATA; line high -> glitch, back to IDLE with no output.
  - DATA: 8 samples, BIT_CNT apart, LSB first.
  - STOP: sample one BIT_CNT later.
    - Stop = 1 -> byte strobe on the next cycle, then IDLE.
    - Stop = 0 -> frameErr_o pulse, byte discarded, go to WAIT_IDLE.
  - WAIT_IDLE: stay until the line is sampled high, then IDLE.
- Parser (runs on each byte strobe):
  - 0xF8-0xFF (realtime): ignored entirely; running status and pending data are unchanged.
  - 0xF0-0xF7: clear running status and the data index.
  - 0x8n / 0x9n with an accepted channel: set running status, data index = 0.
  - Any other status byte (0xA0-0xEF, or a non-matching channel): running status = ignore. Following data bytes are discarded until the next status byte.
  - Data byte with running status none or ignore: discarded.
  - First data byte: latch key, index = 1.
  - Second data byte: execute the message, index = 0. Running status is retained, so further data pairs repeat the message.
- Execute:
  - Note On with velocity > 0: note_o <= key, velocity_o <= vel, gate_o <= 1, nrstPhase_o pulses one cycle. This also applies to the same key or while the gate is already high (retrigger).
  - Note Off, or Note On with velocity 0: if gate_o is high and key == note_o, gate_o <= 0. Otherwise no effect. note_o and velocity_o are retained.
- Latency: outputs update exactly 2 clk_i cycles after the stop-bit sample edge.
- Reset asserted mid-byte aborts reception. After release, the receiver waits for a fresh falling edge.

Optional Feature:
- Macro: MIDI_OMNI_EN.
- Defined: the channel nibble of 0x8n / 0x9n is ignored; all 16 channels are accepted.
- Undefined: only n == CHANNEL is accepted; other channels are treated as ignore status.

Test Plan:
- Basic Note On: default parameters (320 clk/bit), send 0x90 0x3C 0x64 -> note_o=0x3C, velocity_o=0x64, gate_o=1 exactly 2 cycles after the last stop-bit sample; nrstPhase_o high for exactly 1 cycle.
- Running status and Note Off matching:
  - Continue with data bytes 0x40 0x50 -> note_o=0x40, gate_o=1, a second nrstPhase_o pulse.
  - Then 0x80 0x3C 0x00 -> gate_o stays 1 (key does not match).
  - Then 0x40 0x00 under running status 0x80 -> gate_o=0, note_o stays 0x40.
- Velocity-0 off with realtime interleave: send 0x90 0xF8 0x3C 0xFE 0x64 -> same result as the basic Note On; then 0x3C 0x00 -> gate_o=0.
- Channel filter:
  - MIDI_OMNI_EN undefined, CHANNEL=0: send 0x91 0x3C 0x64 -> all outputs unchanged, no nrstPhase_o pulse.
  - MIDI_OMNI_EN defined: same bytes -> gate_o=1, note_o=0x3C.
- Line errors:
  - 100-cycle low glitch on rx_i -> no strobe, outputs unchanged.
  - Byte 0x90 with stop bit forced 0 -> one frameErr_o pulse, outputs unchanged; a following valid 0x90 0x3C 0x64 is decoded correctly.
  - 0xF0 sent between status 0x90 and data bytes -> the data bytes are discarded.
- Reset mid-byte: pulse nrst_i low during bit 4 of 0x90 -> all outputs return to reset values; the next complete message is decoded normally.
